// File: rtl/oled_pkg.sv
// Shared encodings for the OLED request arbiter: OLED_interface mode codes,
// default colour width and arbiter state encodings.
package oled_pkg;

  localparam logic [1:0] MODE_TURNON        = 2'b00;
  localparam logic [1:0] MODE_FILL_SCREEN   = 2'b01;
  localparam logic [1:0] MODE_PIXEL_DISPLAY = 2'b10;

  localparam int DEF_COLOR_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_RUN      = 3'd4,
    ST_FIN      = 3'd5,
    ST_ERR      = 3'd6
  } arb_state_e;

  function automatic logic is_valid_mode(input logic [1:0] m);
    return (m == MODE_TURNON) || (m == MODE_FILL_SCREEN) || (m == MODE_PIXEL_DISPLAY);
  endfunction

  // States that wait on the OLED and are therefore bounded by the timeout.
  function automatic logic is_timed_state(input arb_state_e s);
    return (s == ST_WAIT_RDY) || (s == ST_ISSUE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ. Returns a one-hot grant and a valid flag.
module rr_priority_picker #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/oled_request_arbiter.sv
// Shares one OLED_interface command port between N_REQ requesters: round-robin
// grant, payload latch, START/READY handshake, per-requester done/err pulses.
module oled_request_arbiter
  import oled_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int N_COLOR_BITS = DEF_COLOR_BITS,
  parameter int PIXEL_BITS   = 64,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 2000000
) (
  input  logic                          i_CLK,
  input  logic                          i_RST_N,
  input  logic [N_REQ-1:0]              i_REQ,
  input  logic [2*N_REQ-1:0]            i_REQ_MODE,
  input  logic [N_COLOR_BITS*N_REQ-1:0] i_REQ_TEXT_COLOR,
  input  logic [N_COLOR_BITS*N_REQ-1:0] i_REQ_BG_COLOR,
  input  logic [PIXEL_BITS*N_REQ-1:0]   i_REQ_PIXEL,
  output logic [N_REQ-1:0]              o_GNT,
  output logic [N_REQ-1:0]              o_DONE,
  output logic [N_REQ-1:0]              o_ERR,
  output logic                          o_BUSY,
  input  logic                          i_OLED_READY,
  output logic [1:0]                    o_OLED_MODE,
  output logic                          o_OLED_START,
  output logic [N_COLOR_BITS-1:0]       o_OLED_TEXT_COLOR,
  output logic [N_COLOR_BITS-1:0]       o_OLED_BG_COLOR,
  output logic [PIXEL_BITS-1:0]         o_OLED_PIXEL
);

  localparam int          PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  arb_state_e                state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [31:0]               tmo_q, tmo_d;
  logic [SYNC_STAGES-1:0]    sync_q, sync_d;
  logic [N_REQ-1:0]          gnt_q, gnt_d;
  logic [N_REQ-1:0]          done_q, done_d;
  logic [N_REQ-1:0]          err_q, err_d;
  logic                      busy_q, busy_d;
  logic                      start_q, start_d;
  logic [1:0]                mode_q, mode_d;
  logic [N_COLOR_BITS-1:0]   text_q, text_d;
  logic [N_COLOR_BITS-1:0]   bg_q, bg_d;
  logic [PIXEL_BITS-1:0]     pixel_q, pixel_d;

  logic                      rdy_s;
  logic                      tmo_hit;
  logic [N_REQ-1:0]          pick_gnt;
  logic                      pick_vld;
  logic [1:0]                pick_mode;
  logic [N_COLOR_BITS-1:0]   pick_text;
  logic [N_COLOR_BITS-1:0]   pick_bg;
  logic [PIXEL_BITS-1:0]     pick_pixel;
  logic [PTR_W-1:0]          pick_ptr;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (i_REQ),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  // READY comes from the SCK domain; only the last stage is used.
  always_comb begin
    sync_d[0] = i_OLED_READY;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign rdy_s   = sync_q[SYNC_STAGES-1];
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    pick_mode  = '0;
    pick_text  = '0;
    pick_bg    = '0;
    pick_pixel = '0;
    pick_ptr   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        pick_mode  = i_REQ_MODE[k*2 +: 2];
        pick_text  = i_REQ_TEXT_COLOR[k*N_COLOR_BITS +: N_COLOR_BITS];
        pick_bg    = i_REQ_BG_COLOR[k*N_COLOR_BITS +: N_COLOR_BITS];
        pick_pixel = i_REQ_PIXEL[k*PIXEL_BITS +: PIXEL_BITS];
        pick_ptr   = (k == N_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      tmo_q   <= '0;
      sync_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= '0;
      text_q  <= '0;
      bg_q    <= '0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      sync_q  <= sync_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      text_q  <= text_d;
      bg_q    <= bg_d;
      pixel_q <= pixel_d;
    end
  end

  // Timeout takes precedence over READY in every waiting state.
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (|i_REQ) state_d = ST_ARB;
      ST_ARB: begin
        if (!pick_vld)                    state_d = ST_IDLE;
        else if (!is_valid_mode(pick_mode)) state_d = ST_ERR;
        else                              state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (tmo_hit)    state_d = ST_ERR;
        else if (rdy_s) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (tmo_hit)     state_d = ST_ERR;
        else if (!rdy_s) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tmo_hit)    state_d = ST_ERR;
        else if (rdy_s) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : output_logic
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    start_d = start_q;
    done_d  = '0;
    err_d   = '0;
    mode_d  = mode_q;
    text_d  = text_q;
    bg_d    = bg_q;
    pixel_d = pixel_q;
    ptr_d   = ptr_q;
    tmo_d   = (state_d != state_q) ? '0 :
              (is_timed_state(state_q) ? tmo_q + 32'd1 : '0);
    case (state_q)
      ST_ARB: begin
        if (pick_vld) begin
          gnt_d   = pick_gnt;
          busy_d  = 1'b1;
          mode_d  = pick_mode;
          text_d  = pick_text;
          bg_d    = pick_bg;
          pixel_d = pick_pixel;
          ptr_d   = pick_ptr;
        end
      end
      ST_WAIT_RDY: if (state_d == ST_ISSUE) start_d = 1'b1;
      ST_ISSUE:    if (state_d == ST_RUN)   start_d = 1'b0;
      ST_FIN: begin
        done_d = gnt_q;
        gnt_d  = '0;
        busy_d = 1'b0;
      end
      ST_ERR: begin
        err_d   = gnt_q;
        start_d = 1'b0;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_GNT             = gnt_q;
  assign o_DONE            = done_q;
  assign o_ERR             = err_q;
  assign o_BUSY            = busy_q;
  assign o_OLED_MODE       = mode_q;
  assign o_OLED_START      = start_q;
  assign o_OLED_TEXT_COLOR = text_q;
  assign o_OLED_BG_COLOR   = bg_q;
  assign o_OLED_PIXEL      = pixel_q;

endmodule

// File: tb/tb_oled_request_arbiter.sv
// Directed bench for oled_request_arbiter with a behavioural OLED READY model
// and a done/err scoreboard fed from an expected queue.
module tb_oled_request_arbiter;

  localparam int N    = 3;
  localparam int CW   = 8;
  localparam int PW   = 64;
  localparam int SYNC = 2;
  localparam int TMO  = 1000;
  localparam int IW   = 1 + N + 2 + CW + CW + PW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_mode;
  logic [CW*N-1:0] req_text;
  logic [CW*N-1:0] req_bg;
  logic [PW*N-1:0] req_pixel;
  logic            ready;
  logic [N-1:0]    gnt, done, err;
  logic            busy;
  logic [1:0]      oled_mode;
  logic            oled_start;
  logic [CW-1:0]   oled_text, oled_bg;
  logic [PW-1:0]   oled_pixel;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] mon_act, mon_exp;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            seen     = 0;
  int            cyc, base;
  logic          flag;
  logic          model_stuck = 1'b0;
  logic          stuck_now;

  logic [N-1:0]  t2_gnt [4];
  logic [CW-1:0] t2_bg  [4];

  oled_request_arbiter #(
    .N_REQ        (N),
    .N_COLOR_BITS (CW),
    .PIXEL_BITS   (PW),
    .SYNC_STAGES  (SYNC),
    .TIMEOUT      (TMO)
  ) dut (
    .i_CLK             (clk),
    .i_RST_N           (rst_n),
    .i_REQ             (req),
    .i_REQ_MODE        (req_mode),
    .i_REQ_TEXT_COLOR  (req_text),
    .i_REQ_BG_COLOR    (req_bg),
    .i_REQ_PIXEL       (req_pixel),
    .o_GNT             (gnt),
    .o_DONE            (done),
    .o_ERR             (err),
    .o_BUSY            (busy),
    .i_OLED_READY      (ready),
    .o_OLED_MODE       (oled_mode),
    .o_OLED_START      (oled_start),
    .o_OLED_TEXT_COLOR (oled_text),
    .o_OLED_BG_COLOR   (oled_bg),
    .o_OLED_PIXEL      (oled_pixel)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_slot(input int k, input logic [1:0] m, input logic [CW-1:0] t,
                          input logic [CW-1:0] b, input logic [PW-1:0] p);
    req_mode[k*2 +: 2]   = m;
    req_text[k*CW +: CW] = t;
    req_bg[k*CW +: CW]   = b;
    req_pixel[k*PW +: PW] = p;
  endtask

  task automatic push_exp(input logic is_err, input int k, input logic [1:0] m,
                          input logic [CW-1:0] t, input logic [CW-1:0] b, input logic [PW-1:0] p);
    logic [N-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    exp_q.push_back({is_err, oh, m, t, b, p});
  endtask

  task automatic wait_seen(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (seen < target && c < budget) begin
      tick(1);
      c++;
    end
    check_range(name, seen, target, target);
  endtask

  task automatic wait_start(input int budget, output int c);
    c = 0;
    while (!oled_start && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  task automatic wait_gnt(input int budget);
    int c;
    c = 0;
    while (gnt == '0 && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  // ---------------- OLED READY model ----------------
  // Accepts START 20 cycles after seeing it, then is busy for 200 cycles.
  always begin
    @(posedge clk);
    #1;
    if (oled_start && ready) begin
      stuck_now = model_stuck;
      tick(20);
      if (!stuck_now) begin
        ready = 1'b0;
        tick(200);
        ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (|done || |err) begin
      mon_act = {|err, done | err, oled_mode, oled_text, oled_bg, oled_pixel};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: done=%b err=%b expected no pulse", done, err);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard", mon_act, mon_exp);
      end
      seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    t2_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    t2_bg  = '{8'h03, 8'h1C, 8'hE0, 8'h03};
    rst_n = 1'b0; req = '0; req_mode = '0; req_text = '0; req_bg = '0; req_pixel = '0;
    ready = 1'b0;

    // Power-up: READY low for a long time, then one turn-on transaction.
    set_slot(0, 2'b00, 8'h00, 8'h00, 64'h0);
    push_exp(1'b0, 0, 2'b00, 8'h00, 8'h00, 64'h0);
    req = 3'b001;
    tick(3);
    check("reset_outputs", {gnt, done, err, busy, oled_mode, oled_start, oled_text, oled_bg, oled_pixel}, '0);
    rst_n = 1'b1;
    tick(500);
    check("powerup_hold", {oled_start, gnt, busy}, {1'b0, 3'b001, 1'b1});
    ready = 1'b1;
    wait_start(20, cyc);
    check_range("start_latency", cyc, 1, SYNC + 1);
    wait_seen(1, 2000, "t1_done_count");
    req = '0;
    tick(5);
    check("t1_idle_after", {gnt, busy}, '0);
    check("t1_single_done", seen, 1);

    // All three fill_screen requests held: strict rotation.
    do_reset();
    set_slot(0, 2'b01, 8'h11, 8'h03, 64'h0);
    set_slot(1, 2'b01, 8'h22, 8'h1C, 64'h0);
    set_slot(2, 2'b01, 8'h33, 8'hE0, 64'h0);
    push_exp(1'b0, 0, 2'b01, 8'h11, 8'h03, 64'h0);
    push_exp(1'b0, 1, 2'b01, 8'h22, 8'h1C, 64'h0);
    push_exp(1'b0, 2, 2'b01, 8'h33, 8'hE0, 64'h0);
    push_exp(1'b0, 0, 2'b01, 8'h11, 8'h03, 64'h0);
    base = seen;
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(50);
      check("t2_gnt", gnt, t2_gnt[i]);
      check("t2_bg", oled_bg, t2_bg[i]);
      wait_seen(base + i + 1, 2000, "t2_done_count");
      if (i == 2) req = 3'b001;
      if (i == 3) req = '0;
    end

    // Invalid mode on requester 1, then requester 2 proceeds normally.
    do_reset();
    set_slot(1, 2'b11, 8'h44, 8'h55, 64'hDEAD);
    set_slot(2, 2'b01, 8'h66, 8'h77, 64'h0);
    push_exp(1'b1, 1, 2'b11, 8'h44, 8'h55, 64'hDEAD);
    push_exp(1'b0, 2, 2'b01, 8'h66, 8'h77, 64'h0);
    base = seen;
    req = 3'b110;
    flag = 1'b0;
    cyc = 0;
    while (seen < base + 1 && cyc < 100) begin
      tick(1);
      cyc++;
      if (oled_start) flag = 1'b1;
    end
    check_range("t3_err_count", seen, base + 1, base + 1);
    check("t3_no_start", flag, 1'b0);
    req = 3'b100;
    wait_gnt(50);
    check("t3_next_gnt", gnt, 3'b100);
    wait_seen(base + 2, 2000, "t3_done_count");
    req = '0;

    // READY never drops after START: timeout abort.
    do_reset();
    model_stuck = 1'b1;
    set_slot(0, 2'b00, 8'hA5, 8'h5A, 64'h1234);
    push_exp(1'b1, 0, 2'b00, 8'hA5, 8'h5A, 64'h1234);
    base = seen;
    req = 3'b001;
    wait_start(20, cyc);
    check("t4_start", oled_start, 1'b1);
    cyc = 0;
    while (err[0] !== 1'b1 && cyc < TMO + 50) begin
      tick(1);
      cyc++;
    end
    req = '0;
    check_range("t4_timeout_cycles", cyc, TMO, TMO + 2);
    check("t4_start_dropped", oled_start, 1'b0);
    tick(2);
    check_range("t4_err_count", seen, base + 1, base + 1);
    model_stuck = 1'b0;
    tick(30);

    // Payload change after grant is ignored.
    do_reset();
    set_slot(2, 2'b10, 8'hF0, 8'h0F, 64'hFF818181818181FF);
    push_exp(1'b0, 2, 2'b10, 8'hF0, 8'h0F, 64'hFF818181818181FF);
    base = seen;
    req = 3'b100;
    wait_start(20, cyc);
    check("t5_start", oled_start, 1'b1);
    req_pixel[2*PW +: PW] = 64'h0123456789ABCDEF;
    tick(10);
    check("t5_pixel_issue", oled_pixel, 64'hFF818181818181FF);
    tick(100);
    check("t5_pixel_run", oled_pixel, 64'hFF818181818181FF);
    wait_seen(base + 1, 2000, "t5_done_count");
    req = '0;

    // Reset during RUN, then pointer restarts at requester 0.
    do_reset();
    set_slot(0, 2'b01, 8'h01, 8'h02, 64'h0);
    set_slot(1, 2'b01, 8'h03, 8'h04, 64'h0);
    req = 3'b001;
    wait_start(20, cyc);
    tick(30);
    check("t6_in_run", {oled_start, busy, gnt}, {1'b0, 1'b1, 3'b001});
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t6_after_reset", {oled_start, gnt, busy}, '0);
    push_exp(1'b0, 0, 2'b01, 8'h01, 8'h02, 64'h0);
    push_exp(1'b0, 1, 2'b01, 8'h03, 8'h04, 64'h0);
    base = seen;
    req = 3'b011;
    wait_gnt(50);
    check("t6_ptr_restart", gnt, 3'b001);
    wait_seen(base + 1, 2000, "t6_first_done");
    wait_gnt(50);
    check("t6_second_gnt", gnt, 3'b010);
    wait_seen(base + 2, 2000, "t6_second_done");
    req = '0;
    tick(5);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_idle", {gnt, busy}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
